// File: rtl/aes_round_key_store.sv
// rtl/aes_round_key_store.sv - AES-128 sequential key expansion with 11-entry round-key buffer

module aes_key_schedule (
    input  logic [3:0]   round_in,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);

    // Multiply by x in GF(2^8) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] b;
        p = x;
        b = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            b = gf_mul(b, p);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w     [4];
    logic [31:0] nw    [4];
    logic [31:0] rot;
    logic [31:0] temp;
    logic [7:0]  rcon;

    // Round constant for rounds 1..10
    always_comb begin
        case (round_in)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Columns are words; the row-major bus is transposed in and out around the word recurrence
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w[c][31-8*r -: 8] = key_in[127-8*(4*r+c) -: 8];
            end
        end
        rot   = {w[3][23:0], w[3][31:24]};
        temp  = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        nw[0] = w[0] ^ temp;
        nw[1] = nw[0] ^ w[1];
        nw[2] = nw[1] ^ w[2];
        nw[3] = nw[2] ^ w[3];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                key_out[127-8*(4*r+c) -: 8] = nw[c][31-8*r -: 8];
            end
        end
    end

endmodule

module aes_round_key_store (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start_in,
    input  logic [127:0] key_in,
    output logic         busy_out,
    output logic         ready_out,
    output logic         done_out,
    input  logic         rd_en_in,
    input  logic [3:0]   rd_round_in,
    output logic [127:0] rd_key_out,
    output logic         rd_valid_out
);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   counter;
    logic [127:0] work_key;
    logic [127:0] sched_key;
    logic [10:0]  valid;
    logic [127:0] slot [0:10];
    logic         start_ok;
    logic         expand_last;
    logic         rd_hit;

    assign start_ok    = start_in && (state != S_EXPAND);
    assign expand_last = (state == S_EXPAND) && (counter == 4'd10);
    // Valid bits are sampled before this edge's writes/clears take effect
    assign rd_hit      = rd_en_in && (rd_round_in <= 4'd10) && valid[rd_round_in];

    aes_key_schedule u_sched (
        .round_in (counter),
        .key_in   (work_key),
        .key_out  (sched_key)
    );

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start accepted outside EXPAND, leave EXPAND after round 10
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = S_EXPAND;
            S_EXPAND: if (expand_last) state_nxt = S_READY;
            S_READY:  if (start_ok) state_nxt = S_EXPAND;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy_out  = (state == S_EXPAND);
        ready_out = (state == S_READY);
    end

    // Expansion control: counter, working key, valid bits, completion pulse
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            counter  <= 4'd0;
            work_key <= 128'h0;
            valid    <= 11'h0;
            done_out <= 1'b0;
        end else begin
            done_out <= expand_last;
            if (start_ok) begin
                valid    <= 11'h001;
                counter  <= 4'd1;
                work_key <= key_in;
            end else if (state == S_EXPAND) begin
                valid[counter] <= 1'b1;
                counter        <= counter + 4'd1;
                work_key       <= sched_key;
            end
        end
    end

    // Round-key storage; contents are gated by valid bits so no reset is needed
    always_ff @(posedge clk_in) begin
        if (start_ok) begin
            slot[0] <= key_in;
        end else if (state == S_EXPAND) begin
            slot[counter] <= sched_key;
        end
    end

    // Registered read port, zero key whenever the read misses
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_valid_out <= 1'b0;
            rd_key_out   <= 128'h0;
        end else begin
            rd_valid_out <= rd_hit;
            rd_key_out   <= rd_hit ? slot[rd_round_in] : 128'h0;
        end
    end

endmodule

// File: tb/tb_aes_round_key_store.sv
// tb/tb_aes_round_key_store.sv - directed self-checking bench for aes_round_key_store

module tb_aes_round_key_store;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         start_in = 1'b0;
    logic [127:0] key_in = 128'h0;
    logic         busy_out;
    logic         ready_out;
    logic         done_out;
    logic         rd_en_in = 1'b0;
    logic [3:0]   rd_round_in = 4'd0;
    logic [127:0] rd_key_out;
    logic         rd_valid_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cycles;

    logic [127:0] ka [0:10];
    logic [127:0] kz1;
    logic [127:0] kz10;

    aes_round_key_store dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (start_in),
        .key_in       (key_in),
        .busy_out     (busy_out),
        .ready_out    (ready_out),
        .done_out     (done_out),
        .rd_en_in     (rd_en_in),
        .rd_round_in  (rd_round_in),
        .rd_key_out   (rd_key_out),
        .rd_valid_out (rd_valid_out)
    );

    always #5 clk_in = ~clk_in;

    // FIPS word order (column words) to row-major byte layout
    function automatic logic [127:0] rm(input logic [127:0] f);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(4*r+c) -: 8] = f[127-8*(4*c+r) -: 8];
        return o;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        ka[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        ka[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        ka[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        ka[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        ka[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        ka[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        ka[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        ka[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        ka[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        ka[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        ka[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
        kz1    = 128'h62636363_62636363_62636363_62636363;
        kz10   = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

        // Reset state
        #7;
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_rd_valid", rd_valid_out, 0);
        chk("rst_rd_key", rd_key_out, 0);
        #1 rst_in = 1'b0;
        step();

        // FIPS key expansion with reads trailing generation by one slot
        key_in = rm(ka[0]);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("e0_busy", busy_out, 1);
        chk("e0_ready", ready_out, 0);
        for (int k = 1; k <= 10; k++) begin
            rd_en_in = 1'b1;
            rd_round_in = 4'(k - 1);
            step();
            chk($sformatf("trail_valid_%0d", k), rd_valid_out, 1);
            chk($sformatf("trail_key_%0d", k), rd_key_out, rm(ka[k-1]));
            chk($sformatf("trail_busy_%0d", k), busy_out, (k < 10) ? 1 : 0);
            chk($sformatf("trail_done_%0d", k), done_out, (k == 10) ? 1 : 0);
            chk($sformatf("trail_ready_%0d", k), ready_out, (k == 10) ? 1 : 0);
        end
        rd_round_in = 4'd1;
        step();
        chk("done_drop", done_out, 0);
        chk("ready_hold", ready_out, 1);
        chk("rk1", rd_key_out, rm(ka[1]));
        rd_round_in = 4'd10;
        step();
        chk("rk10", rd_key_out, rm(ka[10]));
        chk("rk10_valid", rd_valid_out, 1);
        rd_round_in = 4'd0;
        step();
        chk("rk0", rd_key_out, rm(ka[0]));

        // Out-of-range and disabled reads
        rd_round_in = 4'd11;
        step();
        chk("r11_valid", rd_valid_out, 0);
        chk("r11_key", rd_key_out, 0);
        rd_round_in = 4'd15;
        step();
        chk("r15_valid", rd_valid_out, 0);
        chk("r15_key", rd_key_out, 0);
        rd_en_in = 1'b0;
        rd_round_in = 4'd1;
        step();
        chk("dis_valid", rd_valid_out, 0);
        chk("dis_key", rd_key_out, 0);

        // Read r=10 at the restart edge returns the old key; zero key expansion
        rd_en_in = 1'b1;
        rd_round_in = 4'd10;
        key_in = 128'h0;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("same_edge_valid", rd_valid_out, 1);
        chk("same_edge_key", rd_key_out, rm(ka[10]));
        chk("restart_ready", ready_out, 0);
        chk("restart_busy", busy_out, 1);
        for (int k = 1; k <= 10; k++) begin
            rd_round_in = (k == 1) ? 4'd10 : 4'(k);
            start_in = (k == 4);
            key_in = (k == 4) ? rm(ka[0]) : 128'h0;
            step();
            start_in = 1'b0;
            chk($sformatf("lead_valid_%0d", k), rd_valid_out, 0);
            chk($sformatf("lead_key_%0d", k), rd_key_out, 0);
            chk($sformatf("lead_busy_%0d", k), busy_out, (k < 10) ? 1 : 0);
            chk($sformatf("lead_done_%0d", k), done_out, (k == 10) ? 1 : 0);
        end
        rd_round_in = 4'd10;
        step();
        chk("zero_rk10", rd_key_out, rm(kz10));
        rd_round_in = 4'd1;
        step();
        chk("zero_rk1", rd_key_out, rm(kz1));

        // Async reset during E6
        rd_en_in = 1'b0;
        key_in = rm(ka[0]);
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            rd_en_in = 1'b1;
            rd_round_in = 4'(k - 1);
            step();
        end
        chk("pre_rst_valid", rd_valid_out, 1);
        #3 rst_in = 1'b1;
        #1;
        chk("arst_busy", busy_out, 0);
        chk("arst_ready", ready_out, 0);
        chk("arst_done", done_out, 0);
        chk("arst_rd_valid", rd_valid_out, 0);
        chk("arst_rd_key", rd_key_out, 0);
        rd_en_in = 1'b0;
        step();
        step();
        chk("arst_hold_done", done_out, 0);
        #2 rst_in = 1'b0;
        rd_en_in = 1'b1;
        rd_round_in = 4'd0;
        step();
        chk("post_rst_r0_valid", rd_valid_out, 0);
        chk("post_rst_ready", ready_out, 0);
        rd_en_in = 1'b0;
        key_in = 128'h0;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        cycles = 0;
        while (!done_out && cycles < 30) begin
            step();
            cycles++;
        end
        chk("fresh_latency", 128'(cycles), 128'd10);
        chk("fresh_ready", ready_out, 1);
        rd_en_in = 1'b1;
        rd_round_in = 4'd10;
        step();
        chk("fresh_rk10", rd_key_out, rm(kz10));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_key_store.md
Name: aes_round_key_store

Overview:
- Sequential AES-128 key expansion engine with a round-key buffer.
- Accepts a cipher key and iterates one aes_key_schedule instance (round_in = 1..10) over 10 cycles.
- Writes each generated round key into an 11-entry register file.
- Serves round keys to the downstream round datapath through a registered read port.

Parameters:
None. The block is AES-128 only, with 10 rounds and 11 round keys fixed.

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_in  input  1  asynchronous active-high reset
start_in  input  1  request expansion of key_in; sampled in IDLE or READY only
key_in  input  128  cipher key, row-major state layout (bits [127:120] = row0/col0, [119:112] = row0/col1, … [7:0] = row3/col3)
busy_out  output  1  high while expanding
ready_out  output  1  high when all 11 round keys are valid
done_out  output  1  one-cycle pulse when expansion completes
rd_en_in  input  1  read request
rd_round_in  input  4  round-key index to read, 0..10
rd_key_out  output  128  round key, same row-major layout
rd_valid_out  output  1  rd_key_out is valid this cycle

Behaviour:
- Reset (async, rst_in=1):
  - State = IDLE; round counter = 0; all 11 slot-valid bits = 0.
  - busy_out = 0, ready_out = 0, done_out = 0, rd_valid_out = 0, rd_key_out = 0.
  - Key storage contents are don't-care after reset; valid bits gate all reads.
- States:
  - IDLE: busy=0, ready=0.
  - EXPAND: busy=1, ready=0.
  - READY: busy=0, ready=1.
- IDLE/READY with start_in=1 at edge E0:
  - Clear all valid bits.
  - slot[0] <= key_in and valid[0] <= 1.
  - Working key register <= key_in; counter <= 1; state <= EXPAND.
- EXPAND, each edge Ek (k = 1..10):
  - aes_key_schedule is driven with round_in = counter and key_in = working key register.
  - slot[k] <= key_out; valid[k] <= 1; working register <= key_out; counter <= counter+1.
  - At E10: state <= READY and done_out <= 1.
  - done_out drops at E11 regardless of inputs.
- Expansion latency: exactly 10 cycles in EXPAND. ready_out and done_out first read high in the cycle after E10.
- start_in while in EXPAND: ignored, with no restart and no queuing.
- start_in in READY: restarts expansion. ready_out drops at E0, and old keys become unreadable immediately because valid bits are cleared.
- key_in is sampled only at E0; later changes have no effect on the running expansion.
- Read port, 1-cycle latency:
  - rd_en_in=1 at edge E with rd_round_in = r ≤ 10 and valid[r]=1 → after E, rd_key_out = slot[r] and rd_valid_out = 1.
  - r > 10, or valid[r] = 0 (including a slot whose write happens at this same edge E) → rd_valid_out = 0 and rd_key_out = 0.
  - rd_en_in=0 → rd_valid_out = 0 and rd_key_out = 0 after the edge.
  - Reads are legal in any state. During EXPAND, slots 0..counter-1 are readable, so the round datapath may trail generation by one cycle.
- Read and start at the same edge: the read sees valid bits as they were before the edge (pre-clear), so it returns the old key with rd_valid_out = 1.
- Reset asserted mid-EXPAND: immediate return to IDLE. All valid bits are cleared, and no done_out pulse is produced.
- All slot values are the exact 128-bit aes_key_schedule outputs. No additional byte reordering is applied.

Test Plan:
1. FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, packed row-major by the bench:
   - start → busy_out high for 10 cycles, then one done_out pulse with ready_out held high.
   - Read r=1 → a0fafe17 88542cb1 23a33939 2a6c7605 (FIPS byte order, transposed to row-major).
   - Read r=10 → d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
   - Read r=0 → the key itself.
2. Pipelined read during EXPAND:
   - Issue rd_round_in = counter-1 every cycle from E1 onward → rd_valid_out = 1 each time with correct keys.
   - Issue rd_round_in = counter → rd_valid_out = 0 and rd_key_out = 0.
3. Out-of-range and disabled reads:
   - rd_round_in = 11 or 15 in READY → rd_valid_out = 0, rd_key_out = 0.
   - rd_en_in = 0 → rd_valid_out = 0.
4. Start handling:
   - start_in pulsed at E4 of an expansion → ignored; completion still at E10 with the original key's schedule.
   - Then start with an all-zero key from READY → round-10 key b4ef5bcb 3e92e211 23e951cf 6f8f188e (FIPS order).
5. Simultaneous read and restart:
   - In READY, read r=10 at the same edge as start → old round-10 key returned with rd_valid_out = 1.
   - Next-cycle read of r=10 → rd_valid_out = 0.
6. Async reset:
   - Assert rst_in asynchronously mid-clock during E6 → all outputs 0 immediately, no done_out pulse.
   - Fresh start after deassertion → expansion completes in 10 cycles.
